// File: rtl/upsample_zero_insert_pkg.sv
// Shared types, default sizes and width helpers for the zero-insert upsampler.
package ups_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ups_state_t;

    localparam int DATA_W_DEF     = 15;
    localparam int L_DEF          = 2;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int UCNT_W_DEF     = 8;

    // Phase register width; kept at least one bit wide.
    function automatic int phase_w(input int l);
        return (l > 1) ? $clog2(l) : 1;
    endfunction

    // FIFO occupancy width: one extra bit so "full" is representable.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/upsample_zero_insert_fifo.sv
// Synchronous FIFO for input-rate samples; async reset on pointers, sync flush that wins.
module ups_fifo
    import ups_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = FIFO_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [cnt_w(DEPTH)-1:0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/upsample_zero_insert.sv
// Zero-insert upsampler feeding the half-band filter: one sample per L-cycle frame, L-1 fills.
// Define UPS_ZOH_EN to repeat the last loaded sample in fill slots instead of inserting zeros.
module upsample_zero_insert
    import ups_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int L          = L_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int UCNT_W     = UCNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_valid,
    output logic [phase_w(L)-1:0]  out_phase,
    output logic [UCNT_W-1:0]      underrun
);

    localparam int             PW   = phase_w(L);
    localparam int             CW   = cnt_w(FIFO_DEPTH);
    localparam logic [PW-1:0]  LAST = PW'(L - 1);

    // Handshake: a transfer happens on any cycle where in_valid && in_ready.
    // in_ready depends only on FIFO occupancy and flush, never on in_valid.
    ups_state_t         state;
    ups_state_t         state_n;
    logic               fifo_push;
    logic               fifo_pop;
    logic [DATA_W-1:0]  fifo_rd;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CW-1:0]      fifo_count;
    logic [DATA_W-1:0]  fill;
    logic [DATA_W-1:0]  data_n;
    logic [PW-1:0]      phase_n;
    logic               valid_n;
    logic [UCNT_W-1:0]  ucnt_n;

    assign in_ready  = !fifo_full && !flush;
    assign fifo_push = in_valid && in_ready;

    ups_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .push    (fifo_push),
        .wr_data (in_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

`ifdef UPS_ZOH_EN
    // out_data always holds the last loaded sample outside phase-0 loads.
    assign fill = out_data;
`else
    assign fill = '0;
`endif

    always_comb begin
        state_n  = state;
        data_n   = out_data;
        phase_n  = out_phase;
        valid_n  = out_valid;
        ucnt_n   = underrun;
        fifo_pop = 1'b0;
        case (state)
            IDLE: begin
                data_n  = '0;
                phase_n = '0;
                valid_n = 1'b0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    data_n   = fifo_rd;
                    valid_n  = 1'b1;
                    state_n  = RUN;
                end
            end
            RUN: begin
                valid_n = 1'b1;
                phase_n = (out_phase == LAST) ? '0 : out_phase + PW'(1);
                if (phase_n != '0) begin
                    data_n = fill;
                end else if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    data_n   = fifo_rd;
                end else begin
                    data_n = fill;
                    if (underrun != {UCNT_W{1'b1}}) ucnt_n = underrun + UCNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out_data  <= '0;
            out_phase <= '0;
            out_valid <= 1'b0;
            underrun  <= '0;
        end else if (flush) begin
            state     <= IDLE;
            out_data  <= '0;
            out_phase <= '0;
            out_valid <= 1'b0;
            underrun  <= '0;
        end else begin
            state     <= state_n;
            out_data  <= data_n;
            out_phase <= phase_n;
            out_valid <= valid_n;
            underrun  <= ucnt_n;
        end
    end

    occupancy_bounded: assert property (@(posedge clk) disable iff (rst)
        fifo_count <= CW'(FIFO_DEPTH));

endmodule

// File: tb/tb_upsample_zero_insert.sv
// Scoreboard bench for upsample_zero_insert (L=2, depth 4); model follows UPS_ZOH_EN if defined.
module tb_upsample_zero_insert;

    localparam int DATA_W     = 15;
    localparam int L          = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int UCNT_W     = 8;
    localparam int PW         = 1;
    localparam int EW         = 1 + PW + DATA_W + UCNT_W;
    localparam int UMAX       = (1 << UCNT_W) - 1;

    logic              clk;
    logic              rst;
    logic              flush;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic [PW-1:0]     out_phase;
    logic [UCNT_W-1:0] underrun;

    upsample_zero_insert #(
        .DATA_W     (DATA_W),
        .L          (L),
        .FIFO_DEPTH (FIFO_DEPTH),
        .UCNT_W     (UCNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_phase (out_phase),
        .underrun  (underrun)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int                checks   = 0;
    int                failures = 0;
    logic [EW-1:0]     exp_q[$];
    logic [DATA_W-1:0] mq[$];
    bit                m_run;
    int                m_phase;
    logic [DATA_W-1:0] m_data;
    int                m_ucnt;
    bit                m_accepted;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_run   = 1'b0;
        m_phase = 0;
        m_data  = '0;
        m_ucnt  = 0;
    endtask

    // Reference: each frame is L slots; slot 0 takes the oldest sample that was
    // accepted on an earlier edge, otherwise it is an underrun slot.
    always @(posedge clk) begin
        logic [DATA_W-1:0] fill_v;
        bit                acc;
        m_accepted = 1'b0;
        if (rst || flush) begin
            model_clear();
        end else begin
`ifdef UPS_ZOH_EN
            fill_v = m_data;
`else
            fill_v = '0;
`endif
            acc = in_valid && (mq.size() < FIFO_DEPTH);
            if (m_run) begin
                m_phase = (m_phase + 1) % L;
                if (m_phase != 0) begin
                    m_data = fill_v;
                end else if (mq.size() > 0) begin
                    m_data = mq.pop_front();
                end else begin
                    m_data = fill_v;
                    if (m_ucnt < UMAX) m_ucnt++;
                end
            end else if (mq.size() > 0) begin
                m_run   = 1'b1;
                m_phase = 0;
                m_data  = mq.pop_front();
            end
            if (acc) begin
                mq.push_back(in_data);
                m_accepted = 1'b1;
            end
        end
        exp_q.push_back({m_run, PW'(m_phase), m_data, UCNT_W'(m_ucnt)});
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        check("in_ready", {31'b0, in_ready}, {31'b0, (!flush && (mq.size() < FIFO_DEPTH))});
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("out_valid", {31'b0, out_valid}, {31'b0, e[EW-1]});
            check("out_phase", 32'(out_phase), 32'(e[EW-2 -: PW]));
            check("out_data",  32'(out_data),  32'(e[DATA_W+UCNT_W-1 -: DATA_W]));
            check("underrun",  32'(underrun),  32'(e[UCNT_W-1:0]));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DATA_W-1:0] d);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        tick();
        while (!m_accepted && n < 100) begin
            tick();
            n++;
        end
        if (!m_accepted) begin
            failures++;
            $display("FAIL send_timeout: sample %0h not accepted within 100 cycles", d);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst      = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_phase", 32'(out_phase), 32'd0);
        check("rst_underrun",  32'(underrun),  32'd0);
        check("rst_in_ready",  {31'b0, in_ready}, 32'd1);

        // back-to-back pair
        tick();
        send(DATA_W'(100));
        send(DATA_W'(-200));
        idle(6);

        // overfill: in_valid held high across six samples
        for (int i = 0; i < 6; i++) send(DATA_W'(i * 1000 + 1));
        idle(20);

        // long idle drives the underrun counter into saturation
        idle(600);
        check("ucnt_sat", 32'(underrun), 32'(UMAX));

        // extremes pass bit-exact
        send(DATA_W'(16383));
        send(DATA_W'(-16384));
        idle(10);

        // flush mid-frame with a concurrent push
        send(DATA_W'(11));
        send(DATA_W'(22));
        in_valid = 1'b1;
        in_data  = DATA_W'(33);
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", {31'b0, out_valid}, 32'd0);
        check("flush_out_data",  32'(out_data), 32'd0);
        check("flush_underrun",  32'(underrun), 32'd0);
        tick();
        check("flush_fifo_empty", {31'b0, out_valid}, 32'd0);
        idle(4);

        // randomized traffic with occasional flushes
        for (int i = 0; i < 2000; i++) begin
            int sel;
            sel      = $urandom_range(0, 9);
            in_valid = ($urandom_range(0, 2) != 0);
            in_data  = (sel == 0) ? DATA_W'(16383) :
                       (sel == 1) ? DATA_W'(-16384) :
                       DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
            flush    = ($urandom_range(0, 60) == 0);
            tick();
        end
        flush = 1'b0;
        idle(4);

        // asynchronous reset in the middle of a frame
        send(DATA_W'(1234));
        send(DATA_W'(-77));
        idle(1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_data",  32'(out_data),  32'd0);
        check("arst_out_valid", {31'b0, out_valid}, 32'd0);
        check("arst_out_phase", 32'(out_phase), 32'd0);
        check("arst_underrun",  32'(underrun),  32'd0);
        model_clear();
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        send(DATA_W'(42));
        idle(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
